// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation codes, issue FSM states and op-class helpers.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE = 4'd0;
    localparam logic [3:0] MULT     = 4'd1;
    localparam logic [3:0] MULTU    = 4'd2;
    localparam logic [3:0] DIV      = 4'd3;
    localparam logic [3:0] DIVU     = 4'd4;
    localparam logic [3:0] MFHI     = 4'd5;
    localparam logic [3:0] MFLO     = 4'd6;
    localparam logic [3:0] MTHI     = 4'd7;
    localparam logic [3:0] MTLO     = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_READ   = 2'd3
    } mdu_state_e;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_read_op(input logic [3:0] op);
        return (op == MFHI) || (op == MFLO);
    endfunction

    function automatic logic is_move_op(input logic [3:0] op);
        return (op == MTHI) || (op == MTLO);
    endfunction

endpackage

// File: rtl/mdu_issue.sv
// Pipeline-side MDU initiator: launches MDU operations from registers, holds
// the pipeline off during the MDU busy window and returns MFHI/MFLO data.
module mdu_issue
    import mdu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    output logic        mdu_start,
    output logic [3:0]  mdu_op,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    input  logic        mdu_busy,
    input  logic [31:0] mdu_do,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        err
);

    mdu_state_e state_r;
    logic [3:0] wd_cnt_r;
    logic [3:0] wd_next_s;
    logic       idle_sem_s;

    // BUSY with the MDU finished behaves exactly like IDLE, saving a bubble.
    assign idle_sem_s = (state_r == ST_IDLE) || ((state_r == ST_BUSY) && !mdu_busy);
    assign req_ready  = idle_sem_s;
    assign wd_next_s  = wd_cnt_r + 4'd1;

    // Issue FSM with registered MDU drive, read return and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            wd_cnt_r  <= 4'd0;
            mdu_start <= 1'b0;
            mdu_op    <= MDU_NONE;
            mdu_a     <= 32'd0;
            mdu_b     <= 32'd0;
            rd_valid  <= 1'b0;
            rd_data   <= 32'd0;
            err       <= 1'b0;
        end else begin
            mdu_start <= 1'b0;
            rd_valid  <= 1'b0;
            if (idle_sem_s) begin
                // Idle defaults, overridden below when a request is taken.
                state_r <= ST_IDLE;
                mdu_op  <= MDU_NONE;
                mdu_a   <= 32'd0;
                mdu_b   <= 32'd0;
                if (req_valid) begin
                    if (is_start_op(req_op)) begin
                        mdu_op    <= req_op;
                        mdu_a     <= req_a;
                        mdu_b     <= req_b;
                        mdu_start <= 1'b1;
                        state_r   <= ST_LAUNCH;
                    end else if (is_move_op(req_op)) begin
                        mdu_op <= req_op;
                        mdu_a  <= req_a;
                    end else if (is_read_op(req_op)) begin
                        mdu_op  <= req_op;
                        state_r <= ST_READ;
                    end else begin
                        // Illegal op codes are swallowed without touching the MDU.
                        state_r <= ST_IDLE;
                    end
                end
            end else begin
                case (state_r)
                    ST_LAUNCH: begin
                        state_r  <= ST_BUSY;
                        wd_cnt_r <= 4'd0;
                    end
                    ST_BUSY: begin
                        if (wd_next_s == 4'(MAX_WAIT)) begin
                            err     <= 1'b1;
                            state_r <= ST_IDLE;
                            mdu_op  <= MDU_NONE;
                            mdu_a   <= 32'd0;
                            mdu_b   <= 32'd0;
                        end else begin
                            wd_cnt_r <= wd_next_s;
                        end
                    end
                    ST_READ: begin
                        rd_data  <= mdu_do;
                        rd_valid <= 1'b1;
                        state_r  <= ST_IDLE;
                        mdu_op   <= MDU_NONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        mdu_op  <= MDU_NONE;
                        mdu_a   <= 32'd0;
                        mdu_b   <= 32'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mdu_issue.md
# mdu_issue

Pipeline-side initiator for the multiply/divide unit. It accepts MDU-class requests from the E stage over a valid/ready handshake and drives the MDU's Start/Op/A/B inputs from registers. It tracks the MDU's Busy window, applies backpressure until the operation completes, and returns MFHI/MFLO read data to the pipeline. It sits between the E-stage register and the MDU; stall logic ANDs `!req_ready` with "E-stage instruction is MDU-class".

## Interface

Parameters:
- MAX_WAIT, 15: maximum cycles spent in BUSY before the watchdog fires.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  E stage presents an MDU-class instruction.
- req_op  in  4  operation code (see Structure).
- req_a  in  32  rs operand.
- req_b  in  32  rt operand.
- req_ready  out  1  request accepted this cycle.
- mdu_start  out  1  to MDU Start; registered, one-cycle pulse.
- mdu_op  out  4  to MDU Op; registered.
- mdu_a  out  32  to MDU A; registered.
- mdu_b  out  32  to MDU B; registered.
- mdu_busy  in  1  from MDU Busy.
- mdu_do  in  32  from MDU DO; combinational on mdu_op.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- rd_data  out  32  MFHI/MFLO result.
- err  out  1  sticky watchdog flag; cleared only by reset.

## Operation

- FSM states: IDLE, LAUNCH, BUSY, READ.
- Acceptance: `req_ready = (state==IDLE) || (state==BUSY && !mdu_busy)`. A request is accepted when `req_valid && req_ready`.
- Start ops (MULT, MULTU, DIV, DIVU):
  - On acceptance, register op/a/b and set mdu_start=1. Go to LAUNCH.
  - In LAUNCH, mdu_start drops to 0 next edge. Go to BUSY.
- BUSY: hold mdu_op = the issued op.
  - When mdu_busy==0, the state is logically idle, so a new request may be accepted in the same cycle with IDLE semantics.
  - If no request is accepted, go to IDLE.
- MTHI/MTLO: on acceptance, register op and a (b=0, start=0) for one cycle. State stays IDLE, so back-to-back moves are allowed.
- MFHI/MFLO:
  - On acceptance, register op. Go to READ.
  - In READ, capture mdu_do into rd_data and pulse rd_valid next cycle. Return to IDLE.
- Illegal op (0 or >8): accepted and dropped. No MDU activity.
- Idle defaults: mdu_op=MDU_NONE, mdu_a=mdu_b=0, mdu_start=0, rd_valid=0. rd_data holds its last value.
- Watchdog: a 4-bit counter clears on entry to BUSY and increments each BUSY cycle with mdu_busy=1. When it reaches MAX_WAIT: set err, go to IDLE.
- No arithmetic in this block; operands pass through unmodified.

## Timing

- Reset values: state IDLE; mdu_start 0; mdu_op MDU_NONE; mdu_a, mdu_b, rd_data 0; rd_valid 0; err 0; req_ready 1 in the cycle after reset deasserts.
- MULT/MULTU accepted in cycle t:
  - mdu_start high in t+1.
  - mdu_busy high t+2..t+6.
  - req_ready high in t+7; HI/LO updated by then.
- DIV/DIVU accepted in cycle t: mdu_busy high t+2..t+11; req_ready high in t+12.
- MFHI/MFLO accepted in cycle t: mdu_op valid in t+1; rd_valid and rd_data in t+2; req_ready high in t+2.
- MTHI accepted in t; MFHI accepted in t+1: rd_data must equal the moved value.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. The MDU shares the reset, so no completion is pending afterwards.
- req_valid with req_ready=0: no side effect. The pipeline holds its request stable.

## Structure

- Shared package mdu_pkg holds:
  - Op constants: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - The FSM state enum.
  - Helper functions is_start_op and is_read_op.
- The MDU uses the same op constants.
- Single module; no sub-module is warranted.

## Test plan

- Reset, then MULT a=0xFFFFFFFE, b=3 -> mdu_start pulses once at t+1; req_ready low t+1..t+6; a following MFLO returns 0xFFFFFFFA and MFHI returns 0xFFFFFFFF.
- DIVU a=100, b=7 -> req_ready low for exactly 11 cycles; MFLO then returns 14 and MFHI returns 2.
- MTHI a=0x12345678 back-to-back with MFHI -> rd_valid two cycles after MFHI acceptance with rd_data=0x12345678.
- DIV completing with MULT presented in the first cycle mdu_busy=0 -> MULT accepted in that cycle and mdu_start pulses the next cycle.
- Reset asserted during BUSY of a DIV -> state returns to IDLE next cycle with req_ready=1, mdu_op=0, and err=0.
- Stub MDU holding mdu_busy=1 indefinitely -> err set after 15 BUSY cycles, state returns to IDLE, and err stays set until reset.
